mux8_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 8:1 single-bit data multiplexer between 8 requesters.
- Requester n owns mux data input n. Select index = {k,j,i}: input a=0 … h=7.
- Block drives the 3-bit mux select, a one-hot grant and a quantum-limited hold.
- Block registers the mux output bit once per granted cycle, so downstream sees a clean valid/data stream tagged with the source index.

---
 rtl/mux8_sched_pkg.sv | 19 +
 rtl/mux8_rr_sched_if.sv | 25 ++
 rtl/rr_pick8.sv | 31 +++
 rtl/mux8_rr_sched.sv | 138 +++++++++++++
 tb/tb_mux8_rr_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux8_sched_pkg.sv
// Shared constants, state encoding and the index-to-grant helper for the
// 8-way round-robin mux scheduler.
package mux8_sched_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// Request/grant/data bundle between the requesters and the mux scheduler.
interface mux8_rr_sched_if;
    import mux8_sched_pkg::*;

    logic             en;
    logic [N-1:0]     req;
    logic             mux_out;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             dout;
    logic             dout_vld;
    logic [SEL_W-1:0] dout_src;

    modport master (
        output en, req, mux_out,
        input  sel, gnt, busy, dout, dout_vld, dout_src
    );

    modport slave (
        input  en, req, mux_out,
        output sel, gnt, busy, dout, dout_vld, dout_src
    );

endinterface

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first requester after 'last', optionally skipping
// one index so the current holder can be excluded at handover.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins;
    // offset N lands back on 'last' itself, which is searched last.
    always_comb begin
        logic [SEL_W-1:0] cand_s;
        logic             hit_s;
        found  = 1'b0;
        idx    = {SEL_W{1'b0}};
        cand_s = {SEL_W{1'b0}};
        hit_s  = 1'b0;
        for (int k = N; k >= 1; k--) begin
            cand_s = last + SEL_W'(k);
            hit_s  = req[cand_s] & ~(excl_en & (cand_s == excl_idx));
            found  = found | hit_s;
            idx    = hit_s ? cand_s : idx;
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of a shared 8:1 bit mux: drives select/grant with a
// quantum-limited hold and registers the mux bit for each granted cycle.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int QUANTUM = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux8_rr_sched_if.slave bus
);

    localparam logic [3:0] CNT_LAST = 4'(QUANTUM - 1);

    state_t           state_r, state_s;
    logic [3:0]       cnt_r, cnt_s;
    logic [SEL_W-1:0] last_r, last_s;
    logic [SEL_W-1:0] sel_r, sel_s;
    logic [N-1:0]     gnt_r, gnt_s;
    logic             busy_r, busy_s;
    logic             dout_r, dout_s;
    logic             vld_r, vld_s;
    logic [SEL_W-1:0] src_r, src_s;

    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             cur_req_s;
    logic             release_s;
    logic             take_s;
    logic [SEL_W-1:0] take_idx_s;

    // While granting, last_r equals the holder, so excluding sel_r yields
    // the next waiting requester in rotation order.
    rr_pick8 u_pick (
        .req      (bus.req),
        .last     (last_r),
        .excl_en  (state_r == GRANT),
        .excl_idx (sel_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Next-state, grant decision and sample-path logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_s     = last_r;
        sel_s      = sel_r;
        gnt_s      = gnt_r;
        busy_s     = busy_r;
        dout_s     = dout_r;
        vld_s      = 1'b0;
        src_s      = src_r;
        take_s     = 1'b0;
        take_idx_s = sel_r;
        cur_req_s  = bus.req[sel_r];
        release_s  = ~cur_req_s | (cnt_r == CNT_LAST) | ~bus.en;

        case (state_r)
            IDLE: begin
                if (bus.en && pick_found_s) begin
                    take_s     = 1'b1;
                    take_idx_s = pick_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                vld_s  = cur_req_s & bus.en;
                dout_s = bus.mux_out;
                src_s  = sel_r;
                if (!release_s) begin
                    cnt_s = cnt_r + 4'd1;
                end else if (bus.en && pick_found_s) begin
                    take_s     = 1'b1;
                    take_idx_s = pick_idx_s;
                end else if (bus.en && cur_req_s) begin
                    // Quantum expired with nobody else waiting: re-grant.
                    take_s     = 1'b1;
                    take_idx_s = sel_r;
                end else begin
                    state_s = IDLE;
                    gnt_s   = {N{1'b0}};
                    busy_s  = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N{1'b0}};
                busy_s  = 1'b0;
            end
        endcase

        if (take_s) begin
            state_s = GRANT;
            sel_s   = take_idx_s;
            gnt_s   = onehot(take_idx_s);
            busy_s  = 1'b1;
            cnt_s   = 4'd0;
            last_s  = take_idx_s;
        end else begin
            cnt_s = cnt_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            last_r  <= 3'd7;
            sel_r   <= 3'd0;
            gnt_r   <= 8'h00;
            busy_r  <= 1'b0;
            dout_r  <= 1'b0;
            vld_r   <= 1'b0;
            src_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            sel_r   <= sel_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
            dout_r  <= dout_s;
            vld_r   <= vld_s;
            src_r   <= src_s;
        end
    end

    assign bus.sel      = sel_r;
    assign bus.gnt      = gnt_r;
    assign bus.busy     = busy_r;
    assign bus.dout     = dout_r;
    assign bus.dout_vld = vld_r;
    assign bus.dout_src = src_r;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: behavioural reference model feeding a scoreboard,
// plus directed scenario checks.
module tb_mux8_rr_sched;
    import mux8_sched_pkg::*;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux8_rr_sched_if bus ();

    mux8_rr_sched #(.QUANTUM(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       dout;
        logic       vld;
        logic [2:0] src;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    logic       m_busy;
    logic [2:0] m_sel;
    logic [7:0] m_gnt;
    logic       m_dout;
    logic       m_vld;
    logic [2:0] m_src;
    logic [2:0] m_last;
    int         m_cnt;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_grant(input logic [2:0] w);
        logic [7:0] one8;
        one8   = 8'h01;
        m_busy = 1'b1;
        m_sel  = w;
        m_gnt  = one8 << w;
        m_cnt  = 0;
        m_last = w;
    endtask

    task automatic m_search(input logic [2:0] from, input bit excl, input logic [2:0] xi,
                            output bit f, output logic [2:0] w);
        logic [2:0] c;
        f = 1'b0;
        w = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            c = 3'((int'(from) + k) % 8);
            if (!f && bus.req[c] && !(excl && c == xi)) begin
                f = 1'b1;
                w = c;
            end
        end
    endtask

    task automatic m_step();
        bit         f;
        logic [2:0] w;
        logic [2:0] c;
        if (rst) begin
            m_busy = 1'b0; m_sel = 3'd0; m_gnt = 8'h00; m_dout = 1'b0;
            m_vld = 1'b0; m_src = 3'd0; m_last = 3'd7; m_cnt = 0;
        end else if (!m_busy) begin
            m_vld = 1'b0;
            m_search(m_last, 1'b0, 3'd0, f, w);
            if (bus.en && f) m_grant(w);
        end else begin
            c      = m_sel;
            m_vld  = bus.req[c] & bus.en;
            m_dout = bus.mux_out;
            m_src  = c;
            if (bus.req[c] && bus.en && m_cnt != Q - 1) begin
                m_cnt++;
            end else begin
                m_search(c, 1'b1, c, f, w);
                if (bus.en && f) m_grant(w);
                else if (bus.en && bus.req[c]) m_grant(c);
                else begin
                    m_busy = 1'b0;
                    m_gnt  = 8'h00;
                end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        m_step();
        e = '{gnt: m_gnt, sel: m_sel, busy: m_busy, dout: m_dout, vld: m_vld, src: m_src};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_gnt",  bus.gnt,      e.gnt);
        check_eq("sb_sel",  bus.sel,      e.sel);
        check_eq("sb_busy", bus.busy,     e.busy);
        check_eq("sb_dout", bus.dout,     e.dout);
        check_eq("sb_vld",  bus.dout_vld, e.vld);
        check_eq("sb_src",  bus.dout_src, e.src);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] one8;
        one8        = 8'h01;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.req     = 8'h00;
        bus.mux_out = 1'b0;
        cycle();
        do_reset();
        check_eq("rst_gnt",  bus.gnt,  8'h00);
        check_eq("rst_busy", bus.busy, 8'h00);

        // reset mid-grant
        bus.en = 1'b1; bus.req = 8'h08;
        cycle();
        check_eq("mid_gnt0", bus.gnt, 8'h08);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_gnt",  bus.gnt,      8'h00);
        check_eq("mid_rst_sel",  bus.sel,      8'h00);
        check_eq("mid_rst_busy", bus.busy,     8'h00);
        check_eq("mid_rst_vld",  bus.dout_vld, 8'h00);
        rst = 1'b0; bus.req = 8'h81;
        cycle();
        check_eq("post_rst_gnt", bus.gnt, 8'h01);
        check_eq("post_rst_sel", bus.sel, 8'h00);
        bus.req = 8'h00;
        cycle(); cycle();

        // round-robin with all requesting
        do_reset();
        bus.req = 8'hFF;
        cycle();
        check_eq("rr_first", bus.gnt, 8'h01);
        for (int i = 1; i < 36; i++) begin
            cycle();
            check_eq("rr_gnt",  bus.gnt,  one8 << ((i / 4) % 8));
            check_eq("rr_sel",  bus.sel,  8'((i / 4) % 8));
            check_eq("rr_busy", bus.busy, 8'h01);
        end

        // early release
        do_reset();
        bus.req = 8'h24;
        cycle(); check_eq("er_gnt_a", bus.gnt, 8'h04);
        cycle(); check_eq("er_gnt_b", bus.gnt, 8'h04);
        bus.req = 8'h20;
        cycle(); check_eq("er_gnt_c", bus.gnt, 8'h20);
        bus.req = 8'h00;
        cycle(); cycle();

        // data path on index 6
        do_reset();
        bus.req = 8'h40;
        cycle();
        check_eq("dp_gnt", bus.gnt, 8'h40);
        bus.mux_out = 1'b1; cycle();
        check_eq("dp_vld1", bus.dout_vld, 8'h01); check_eq("dp_d1", bus.dout, 8'h01);
        check_eq("dp_src1", bus.dout_src, 8'h06);
        bus.mux_out = 1'b0; cycle();
        check_eq("dp_vld2", bus.dout_vld, 8'h01); check_eq("dp_d2", bus.dout, 8'h00);
        bus.mux_out = 1'b1; cycle();
        check_eq("dp_vld3", bus.dout_vld, 8'h01); check_eq("dp_d3", bus.dout, 8'h01);
        bus.req = 8'h00; cycle();
        check_eq("dp_vld_end", bus.dout_vld, 8'h00);
        cycle();

        // sole requester keeps the mux past quantum expiry
        bus.req = 8'h10;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("sole_gnt",  bus.gnt,  8'h10);
            check_eq("sole_busy", bus.busy, 8'h01);
        end
        bus.req = 8'h00;
        cycle(); cycle();

        // enable drop then re-enable
        do_reset();
        bus.req = 8'h03;
        cycle(); check_eq("en_gnt0", bus.gnt, 8'h01);
        bus.en = 1'b0;
        cycle();
        check_eq("en_off_gnt",  bus.gnt,  8'h00);
        check_eq("en_off_busy", bus.busy, 8'h00);
        bus.en = 1'b1;
        cycle(); check_eq("en_on_gnt", bus.gnt, 8'h02);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            bus.en      = ($urandom_range(0, 9) != 0);
            bus.mux_out = 1'($urandom);
            rst         = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
